// File: rtl/mips_dec_exec_pkg.sv
// Shared MIPS decode constants, ALU control codes and control-word types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-decoder to ALU-control-decoder encoding
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    // Full main-decoder output
    typedef struct packed {
        logic   regdst;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch_eq;
        logic   branch_ne;
        aluop_t aluop;
        logic   jump;
    } ctrl_t;

    // Controls carried forward into the EX/MEM register
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
        logic branch_eq;
        logic branch_ne;
        logic jump;
    } ex_ctrl_t;

endpackage

// File: rtl/mips_dec_exec_if.sv
// Bundle of ID-stage inputs and EX/MEM-register outputs for mips_dec_exec.
// Latency: n/a (wires only); ovf_q exists only when ALU_OVF_EN is defined.
// Backpressure: none; stall/flush are carried as bubble/flush.
interface mips_dec_exec_if #(parameter int W = 32);
    logic [31:0]  instr;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         bubble;
    logic         flush;

    logic         regwrite_q;
    logic         memtoreg_q;
    logic         memread_q;
    logic         memwrite_q;
    logic         branch_eq_q;
    logic         branch_ne_q;
    logic         jump_q;
    logic [4:0]   wrreg_q;
    logic [W-1:0] alurslt_q;
    logic         zero_q;
    logic [W-1:0] data2_q;
`ifdef ALU_OVF_EN
    logic         ovf_q;
`endif

    modport master (
`ifdef ALU_OVF_EN
        input  ovf_q,
`endif
        output instr, rs_data, rt_data, bubble, flush,
        input  regwrite_q, memtoreg_q, memread_q, memwrite_q,
               branch_eq_q, branch_ne_q, jump_q,
               wrreg_q, alurslt_q, zero_q, data2_q
    );

    modport slave (
`ifdef ALU_OVF_EN
        output ovf_q,
`endif
        input  instr, rs_data, rt_data, bubble, flush,
        output regwrite_q, memtoreg_q, memread_q, memwrite_q,
               branch_eq_q, branch_ne_q, jump_q,
               wrreg_q, alurslt_q, zero_q, data2_q
    );
endinterface

// File: rtl/mips_dec_exec_alu_core.sv
// Combinational 32-bit ALU: and/or/add/sub/nor/slt, zero flag, optional overflow (ALU_OVF_EN).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
import mips_pkg::*;

module mips_alu_core #(
    parameter int W = 32
) (
    input  logic [3:0]   ctl_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] out_o,
`ifdef ALU_OVF_EN
    output logic         ovf_o,
`endif
    output logic         zero_o
);
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         lt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    // Select the operation result; unlisted control codes yield zero
    always_comb begin
        out_o = '0;
        case (ctl_i)
            ALU_AND: out_o = a_i & b_i;
            ALU_OR:  out_o = a_i | b_i;
            ALU_ADD: out_o = sum;
            ALU_SUB: out_o = diff;
            ALU_NOR: out_o = ~(a_i | b_i);
            ALU_SLT: out_o = {{(W-1){1'b0}}, lt};
            default: out_o = '0;
        endcase
    end

    assign zero_o = (out_o == '0);

`ifdef ALU_OVF_EN
    // Signed overflow: operands' effective signs agree but the result sign differs
    always_comb begin
        ovf_o = 1'b0;
        case (ctl_i)
            ALU_ADD: ovf_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1]  != a_i[W-1]);
            ALU_SUB: ovf_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            default: ovf_o = 1'b0;
        endcase
    end
`endif
endmodule

// File: rtl/mips_dec_exec.sv
// Main decode + ALU-control decode + ALU, captured in an EX/MEM register; ALU_OVF_EN adds ovf_q.
// Latency: 1 cycle from instr/operands to registered outputs; updates every edge.
// Backpressure: none; bubble zeroes controls only, flush zeroes everything (flush wins).
import mips_pkg::*;

module mips_dec_exec #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mips_dec_exec_if.slave bus
);
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [4:0]   rt_fld;
    logic [4:0]   rd_fld;
    logic [15:0]  imm;
    logic         unused_instr_bits;

    ctrl_t        dec;
    ex_ctrl_t     ex_ctrl;
    logic [3:0]   alu_ctl;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_out;
    logic         alu_zero;

    ex_ctrl_t     ctrl_q;
    logic [4:0]   wrreg_q, wrreg_d;
    logic [W-1:0] alurslt_q;
    logic         zero_q;
    logic [W-1:0] data2_q;

    assign opcode = bus.instr[31:26];
    assign rt_fld = bus.instr[20:16];
    assign rd_fld = bus.instr[15:11];
    assign imm    = bus.instr[15:0];
    assign funct  = bus.instr[5:0];
    // rs and shamt fields are not needed here: rs_data arrives pre-read
    assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[10:6]};

    // Main decoder: opcode to control word, unknown opcodes decode as NOP
    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                dec.branch_eq = 1'b1;
                dec.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                dec.branch_ne = 1'b1;
                dec.aluop     = ALUOP_SUB;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_J:    dec.jump = 1'b1;
            default: dec = '0;
        endcase
    end

    // ALU-control decoder: aluop plus funct to ALU operation code
    always_comb begin
        alu_ctl = ALU_AND;
        case (dec.aluop)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_NOR:  alu_ctl = ALU_NOR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_AND;
                endcase
            end
            default: alu_ctl = ALU_AND;
        endcase
    end

    assign op_b    = dec.alusrc ? {{(W-16){imm[15]}}, imm} : bus.rt_data;
    assign wrreg_d = dec.regdst ? rd_fld : rt_fld;

    assign ex_ctrl = '{regwrite:  dec.regwrite,
                       memtoreg:  dec.memtoreg,
                       memread:   dec.memread,
                       memwrite:  dec.memwrite,
                       branch_eq: dec.branch_eq,
                       branch_ne: dec.branch_ne,
                       jump:      dec.jump};

`ifdef ALU_OVF_EN
    logic alu_ovf;
    logic ovf_q;
`endif

    mips_alu_core #(.W(W)) u_alu (
        .ctl_i  (alu_ctl),
        .a_i    (bus.rs_data),
        .b_i    (op_b),
        .out_o  (alu_out),
`ifdef ALU_OVF_EN
        .ovf_o  (alu_ovf),
`endif
        .zero_o (alu_zero)
    );

    // EX/MEM register: flush clears all, bubble clears controls but keeps datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            wrreg_q   <= '0;
            alurslt_q <= '0;
            zero_q    <= 1'b0;
            data2_q   <= '0;
        end else if (bus.flush) begin
            ctrl_q    <= '0;
            wrreg_q   <= '0;
            alurslt_q <= '0;
            zero_q    <= 1'b0;
            data2_q   <= '0;
        end else begin
            ctrl_q    <= bus.bubble ? '0 : ex_ctrl;
            wrreg_q   <= wrreg_d;
            alurslt_q <= alu_out;
            zero_q    <= alu_zero;
            data2_q   <= bus.rt_data;
        end
    end

`ifdef ALU_OVF_EN
    // Overflow flag follows the datapath: cleared by reset/flush, kept through bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.flush) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= alu_ovf;
        end
    end

    assign bus.ovf_q = ovf_q;
`endif

    assign bus.regwrite_q  = ctrl_q.regwrite;
    assign bus.memtoreg_q  = ctrl_q.memtoreg;
    assign bus.memread_q   = ctrl_q.memread;
    assign bus.memwrite_q  = ctrl_q.memwrite;
    assign bus.branch_eq_q = ctrl_q.branch_eq;
    assign bus.branch_ne_q = ctrl_q.branch_ne;
    assign bus.jump_q      = ctrl_q.jump;
    assign bus.wrreg_q     = wrreg_q;
    assign bus.alurslt_q   = alurslt_q;
    assign bus.zero_q      = zero_q;
    assign bus.data2_q     = data2_q;
endmodule

// File: tb/tb_mips_dec_exec.sv
// Directed bench for mips_dec_exec with hand-computed expectations.
// Latency: checks one edge after each applied vector.
// Backpressure: n/a.
module tb_mips_dec_exec;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mips_dec_exec_if #(.W(32)) bus ();

    mips_dec_exec #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word order: regwrite memtoreg memread memwrite branch_eq branch_ne jump
    function automatic logic [31:0] ctlv();
        return {25'd0, bus.regwrite_q, bus.memtoreg_q, bus.memread_q, bus.memwrite_q,
                bus.branch_eq_q, bus.branch_ne_q, bus.jump_q};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one vector after the falling edge, then sample 1ns after the next rising edge
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic bub, input logic fl);
        @(negedge clk);
        bus.instr   = i;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.bubble  = bub;
        bus.flush   = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.instr   = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.bubble  = 1'b0;
        bus.flush   = 1'b0;

        #12;
        chk("rst_hold_ctl", ctlv(), 32'h0);
        chk("rst_hold_alu", bus.alurslt_q, 32'h0);
        rst_n = 1'b1;

        // add $3,$1,$2 : 5 + 7
        apply(32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
        chk("add_rslt",  bus.alurslt_q, 32'd12);
        chk("add_ctl",   ctlv(), 32'b1000000);
        chk("add_wrreg", {27'd0, bus.wrreg_q}, 32'd3);
        chk("add_zero",  {31'd0, bus.zero_q}, 32'd0);
        chk("add_data2", bus.data2_q, 32'd7);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl",   ctlv(), 32'h0);
        chk("async_rst_rslt",  bus.alurslt_q, 32'h0);
        chk("async_rst_wrreg", {27'd0, bus.wrreg_q}, 32'd0);
        chk("async_rst_data2", bus.data2_q, 32'h0);
        #1 rst_n = 1'b1;

        // slt: -1 < 1 signed
        apply(32'h0022182A, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        chk("slt_rslt", bus.alurslt_q, 32'd1);

        // sub equal operands -> zero
        apply(32'h00221822, 32'd9, 32'd9, 1'b0, 1'b0);
        chk("sub_rslt", bus.alurslt_q, 32'd0);
        chk("sub_zero", {31'd0, bus.zero_q}, 32'd1);

        // sub wraps
        apply(32'h00221822, 32'd0, 32'd1, 1'b0, 1'b0);
        chk("sub_wrap", bus.alurslt_q, 32'hFFFFFFFF);

        // and / or / nor / unknown funct (acts as and)
        apply(32'h00221824, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
        chk("and_rslt", bus.alurslt_q, 32'h0000F000);
        apply(32'h00221825, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
        chk("or_rslt", bus.alurslt_q, 32'h0000FFF0);
        apply(32'h00221827, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
        chk("nor_rslt", bus.alurslt_q, 32'hFFFF000F);
        apply(32'h00221821, 32'd6, 32'd3, 1'b0, 1'b0);
        chk("badfn_rslt", bus.alurslt_q, 32'd2);

        // lw $1,16($2)
        apply(32'h8C410010, 32'h100, 32'h55, 1'b0, 1'b0);
        chk("lw_rslt",  bus.alurslt_q, 32'h110);
        chk("lw_ctl",   ctlv(), 32'b1110000);
        chk("lw_wrreg", {27'd0, bus.wrreg_q}, 32'd1);

        // sw $1,-4($2)
        apply(32'hAC41FFFC, 32'h100, 32'hAB, 1'b0, 1'b0);
        chk("sw_rslt",  bus.alurslt_q, 32'hFC);
        chk("sw_ctl",   ctlv(), 32'b0001000);
        chk("sw_data2", bus.data2_q, 32'hAB);

        // beq with equal operands
        apply(32'h10220003, 32'd4, 32'd4, 1'b0, 1'b0);
        chk("beq_ctl",  ctlv(), 32'b0000100);
        chk("beq_zero", {31'd0, bus.zero_q}, 32'd1);

        // bne with unequal operands
        apply(32'h14220003, 32'd4, 32'd5, 1'b0, 1'b0);
        chk("bne_ctl",  ctlv(), 32'b0000010);
        chk("bne_rslt", bus.alurslt_q, 32'hFFFFFFFF);
        chk("bne_zero", {31'd0, bus.zero_q}, 32'd0);

        // addi $2,$1,-1
        apply(32'h2022FFFF, 32'd10, 32'd77, 1'b0, 1'b0);
        chk("addi_rslt",  bus.alurslt_q, 32'd9);
        chk("addi_ctl",   ctlv(), 32'b1000000);
        chk("addi_wrreg", {27'd0, bus.wrreg_q}, 32'd2);

        // j: only jump asserted
        apply(32'h08000010, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("j_ctl", ctlv(), 32'b0000001);

        // add under bubble: controls dropped, datapath captured
        apply(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("bub_ctl",   ctlv(), 32'h0);
        chk("bub_rslt",  bus.alurslt_q, 32'd12);
        chk("bub_wrreg", {27'd0, bus.wrreg_q}, 32'd3);
        chk("bub_data2", bus.data2_q, 32'd7);

        // flush with bubble: everything cleared
        apply(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b1);
        chk("flush_ctl",   ctlv(), 32'h0);
        chk("flush_rslt",  bus.alurslt_q, 32'h0);
        chk("flush_wrreg", {27'd0, bus.wrreg_q}, 32'd0);
        chk("flush_data2", bus.data2_q, 32'h0);

        // unknown opcode 0x3F: NOP controls, ALU computes and (aluop 00 is add? no: NOP aluop 00 -> add)
        apply(32'hFC221820, 32'd2, 32'd3, 1'b0, 1'b0);
        chk("unk_ctl",  ctlv(), 32'h0);
        chk("unk_rslt", bus.alurslt_q, 32'd5);

`ifdef ALU_OVF_EN
        apply(32'h00221820, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        chk("ovf_add_flag", {31'd0, bus.ovf_q}, 32'd1);
        chk("ovf_add_rslt", bus.alurslt_q, 32'h80000000);
        apply(32'h00221822, 32'h80000000, 32'd1, 1'b1, 1'b0);
        chk("ovf_sub_bub", {31'd0, bus.ovf_q}, 32'd1);
        apply(32'h00221824, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        chk("ovf_and", {31'd0, bus.ovf_q}, 32'd0);
        apply(32'h00221820, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
        chk("ovf_flush", {31'd0, bus.ovf_q}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
